// File: rtl/esm_retire_buffer.sv
// ----------------------------------------------------------------------------
// esm_retire_buffer
//   Reorder/retire stage behind the ESM scheduler. Out-of-order completions
//   land in their original slot; words are released to the commit consumer
//   strictly in slot order 0..bs-1, wrapping to slot 0 after each batch.
//
// Ports
//   clk, rst_n   clock (rising edge), async active-low reset
//   cmp_valid    completion strobe
//   cmp_index    original slot of the completed instruction
//   cmp_instr    completed instruction word
//   flush        synchronous clear of all slots and head
//   ret_ready    consumer accepts the retire word
//   ret_valid    head slot holds a completed instruction
//   ret_instr    instruction at head (mux of registered slot data)
//   ret_index    head slot number
//   batch_done   1-cycle pulse after slot bs-1 retires
//   dup_err      1-cycle pulse after an illegal completion
//   pending      completed but not yet retired slots
//   retire_cnt   total retirements, wraps at 2^16
// ----------------------------------------------------------------------------
module esm_retire_buffer #(
    parameter int unsigned Instruction_word_size = 32,
    parameter int unsigned bs                    = 16,
    localparam int unsigned BS_BITS              = $clog2(bs)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmp_valid,
    input  logic [BS_BITS-1:0]               cmp_index,
    input  logic [Instruction_word_size-1:0] cmp_instr,
    input  logic                             flush,
    input  logic                             ret_ready,
    output logic                             ret_valid,
    output logic [Instruction_word_size-1:0] ret_instr,
    output logic [BS_BITS-1:0]               ret_index,
    output logic                             batch_done,
    output logic                             dup_err,
    output logic [BS_BITS:0]                 pending,
    output logic [15:0]                      retire_cnt
);

    localparam logic [BS_BITS-1:0] LAST_SLOT = BS_BITS'(bs - 1);

    logic [Instruction_word_size-1:0] r_data [bs];
    logic [bs-1:0]                    r_valid;
    logic [BS_BITS-1:0]               r_head;
    logic [BS_BITS:0]                 r_pending;
    logic [15:0]                      r_retire_cnt;
    logic                             r_batch_done;
    logic                             r_dup_err;

    logic w_legal;
    logic w_acc;
    logic w_ret;
    logic w_dup;

    // Legality is judged against the current (pre-wrap) head.
    assign w_legal = (cmp_index >= r_head) && !r_valid[cmp_index];
    assign w_acc   = cmp_valid && w_legal && !flush;
    assign w_dup   = cmp_valid && !w_legal && !flush;
    assign w_ret   = r_valid[r_head] && ret_ready && !flush;

    // Slot payload; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_data[cmp_index] <= cmp_instr;
        end
    end

    // Accept and retire never target the same slot: an accept needs the
    // slot empty, a retire needs the head slot full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_head       <= '0;
            r_pending    <= '0;
            r_retire_cnt <= '0;
            r_batch_done <= 1'b0;
            r_dup_err    <= 1'b0;
        end else begin
            r_batch_done <= w_ret && (r_head == LAST_SLOT);
            r_dup_err    <= w_dup;
            if (flush) begin
                r_valid   <= '0;
                r_head    <= '0;
                r_pending <= '0;
            end else begin
                if (w_ret) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + BS_BITS'(1);
                    r_retire_cnt    <= r_retire_cnt + 16'd1;
                end
                if (w_acc) begin
                    r_valid[cmp_index] <= 1'b1;
                end
                case ({w_acc, w_ret})
                    2'b10:   r_pending <= r_pending + (BS_BITS+1)'(1);
                    2'b01:   r_pending <= r_pending - (BS_BITS+1)'(1);
                    default: r_pending <= r_pending;
                endcase
            end
        end
    end

    assign ret_valid  = r_valid[r_head];
    assign ret_instr  = r_data[r_head];
    assign ret_index  = r_head;
    assign batch_done = r_batch_done;
    assign dup_err    = r_dup_err;
    assign pending    = r_pending;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_esm_retire_buffer.sv
// ----------------------------------------------------------------------------
// tb_esm_retire_buffer
//   Directed bench for esm_retire_buffer with bs=4, 32-bit words. Each step
//   drives inputs 1ns after a rising edge and checks outputs 1ns after the
//   following rising edge against hand-computed values.
// ----------------------------------------------------------------------------
module tb_esm_retire_buffer;

    logic        clk;
    logic        rst_n;
    logic        cmp_valid;
    logic [1:0]  cmp_index;
    logic [31:0] cmp_instr;
    logic        flush;
    logic        ret_ready;
    logic        ret_valid;
    logic [31:0] ret_instr;
    logic [1:0]  ret_index;
    logic        batch_done;
    logic        dup_err;
    logic [2:0]  pending;
    logic [15:0] retire_cnt;

    int n_vec = 0;
    int n_err = 0;

    esm_retire_buffer #(
        .Instruction_word_size(32),
        .bs(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmp_valid(cmp_valid),
        .cmp_index(cmp_index),
        .cmp_instr(cmp_instr),
        .flush(flush),
        .ret_ready(ret_ready),
        .ret_valid(ret_valid),
        .ret_instr(ret_instr),
        .ret_index(ret_index),
        .batch_done(batch_done),
        .dup_err(dup_err),
        .pending(pending),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1ns after the edge.
    task automatic step(input logic cv, input logic [1:0] ci, input logic [31:0] cd,
                        input logic rr, input logic fl);
        cmp_valid = cv;
        cmp_index = ci;
        cmp_instr = cd;
        ret_ready = rr;
        flush     = fl;
        @(posedge clk);
        #1;
        cmp_valid = 1'b0;
        flush     = 1'b0;
    endtask

    // Common status check: valid, index, pending, retire count.
    task automatic st(input string tag, input logic rv, input logic [1:0] idx,
                      input logic [2:0] pd, input logic [15:0] rc);
        chk({tag, ".rv"},  32'(ret_valid),  32'(rv));
        chk({tag, ".idx"}, 32'(ret_index),  32'(idx));
        chk({tag, ".pd"},  32'(pending),    32'(pd));
        chk({tag, ".rc"},  32'(retire_cnt), 32'(rc));
    endtask

    initial begin
        rst_n     = 1'b0;
        cmp_valid = 1'b0;
        cmp_index = 2'd0;
        cmp_instr = 32'd0;
        flush     = 1'b0;
        ret_ready = 1'b0;
        #12;
        st("reset", 1'b0, 2'd0, 3'd0, 16'd0);
        chk("reset.bd",  32'(batch_done), 32'd0);
        chk("reset.dup", 32'(dup_err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // In-order completions with the consumer always ready.
        step(1'b1, 2'd0, 32'hA000_0000, 1'b1, 1'b0);
        st("ino0", 1'b1, 2'd0, 3'd1, 16'd0);
        chk("ino0.instr", ret_instr, 32'hA000_0000);
        step(1'b1, 2'd1, 32'hA000_0001, 1'b1, 1'b0);
        st("ino1", 1'b1, 2'd1, 3'd1, 16'd1);
        chk("ino1.instr", ret_instr, 32'hA000_0001);
        step(1'b1, 2'd2, 32'hA000_0002, 1'b1, 1'b0);
        st("ino2", 1'b1, 2'd2, 3'd1, 16'd2);
        chk("ino2.instr", ret_instr, 32'hA000_0002);
        step(1'b1, 2'd3, 32'hA000_0003, 1'b1, 1'b0);
        st("ino3", 1'b1, 2'd3, 3'd1, 16'd3);
        chk("ino3.instr", ret_instr, 32'hA000_0003);
        chk("ino3.bd", 32'(batch_done), 32'd0);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("ino_wrap", 1'b0, 2'd0, 3'd0, 16'd4);
        chk("ino_wrap.bd", 32'(batch_done), 32'd1);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("ino_after.bd", 32'(batch_done), 32'd0);

        // Reverse-order completions: nothing retires until slot 0 lands.
        step(1'b1, 2'd3, 32'hB000_0003, 1'b1, 1'b0);
        st("rev3", 1'b0, 2'd0, 3'd1, 16'd4);
        step(1'b1, 2'd2, 32'hB000_0002, 1'b1, 1'b0);
        st("rev2", 1'b0, 2'd0, 3'd2, 16'd4);
        step(1'b1, 2'd1, 32'hB000_0001, 1'b1, 1'b0);
        st("rev1", 1'b0, 2'd0, 3'd3, 16'd4);
        step(1'b1, 2'd0, 32'hB000_0000, 1'b1, 1'b0);
        st("rev0", 1'b1, 2'd0, 3'd4, 16'd4);
        chk("rev0.instr", ret_instr, 32'hB000_0000);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("revd1", 1'b1, 2'd1, 3'd3, 16'd5);
        chk("revd1.instr", ret_instr, 32'hB000_0001);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("revd2", 1'b1, 2'd2, 3'd2, 16'd6);
        chk("revd2.instr", ret_instr, 32'hB000_0002);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("revd3", 1'b1, 2'd3, 3'd1, 16'd7);
        chk("revd3.instr", ret_instr, 32'hB000_0003);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("revd4", 1'b0, 2'd0, 3'd0, 16'd8);
        chk("revd4.bd", 32'(batch_done), 32'd1);

        // Duplicate completion keeps the first word.
        step(1'b1, 2'd2, 32'hC000_0002, 1'b0, 1'b0);
        st("dup_a", 1'b0, 2'd0, 3'd1, 16'd8);
        chk("dup_a.dup", 32'(dup_err), 32'd0);
        step(1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0, 1'b0);
        st("dup_b", 1'b0, 2'd0, 3'd1, 16'd8);
        chk("dup_b.dup", 32'(dup_err), 32'd1);
        step(1'b1, 2'd0, 32'hC000_0000, 1'b0, 1'b0);
        chk("dup_c.dup", 32'(dup_err), 32'd0);
        step(1'b1, 2'd1, 32'hC000_0001, 1'b0, 1'b0);
        st("dup_d", 1'b1, 2'd0, 3'd3, 16'd8);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("dup_r0", 1'b1, 2'd1, 3'd2, 16'd9);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("dup_r1", 1'b1, 2'd2, 3'd1, 16'd10);
        chk("dup_r1.instr", ret_instr, 32'hC000_0002);
        // Stale completion to an already-retired slot.
        step(1'b1, 2'd0, 32'h57A1_E000, 1'b0, 1'b0);
        st("stale", 1'b1, 2'd2, 3'd1, 16'd10);
        chk("stale.dup", 32'(dup_err), 32'd1);
        // Completion and retire to different slots in the same cycle.
        step(1'b1, 2'd3, 32'hC000_0003, 1'b1, 1'b0);
        st("both", 1'b1, 2'd3, 3'd1, 16'd11);
        chk("both.dup", 32'(dup_err), 32'd0);
        chk("both.instr", ret_instr, 32'hC000_0003);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("dup_wrap", 1'b0, 2'd0, 3'd0, 16'd12);
        chk("dup_wrap.bd", 32'(batch_done), 32'd1);

        // Backpressure: fill all slots, hold ret_ready low.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'(i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
        end
        st("bp_fill", 1'b1, 2'd0, 3'd4, 16'd12);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
            st("bp_hold", 1'b1, 2'd0, 3'd4, 16'd12);
            chk("bp_hold.instr", ret_instr, 32'hE000_0000);
        end
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
            st("bp_drain", 1'b1, 2'(i), 3'(4 - i), 16'(12 + i));
            chk("bp_drain.instr", ret_instr, 32'hE000_0000 + 32'(i));
        end
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("bp_end", 1'b0, 2'd0, 3'd0, 16'd16);
        chk("bp_end.bd", 32'(batch_done), 32'd1);

        // Flush overrides a same-cycle completion and retire.
        step(1'b1, 2'd0, 32'hF000_0000, 1'b0, 1'b0);
        step(1'b1, 2'd2, 32'hF000_0002, 1'b0, 1'b0);
        st("fl_pre", 1'b1, 2'd0, 3'd2, 16'd16);
        step(1'b1, 2'd1, 32'hF000_0001, 1'b1, 1'b1);
        st("fl_post", 1'b0, 2'd0, 3'd0, 16'd16);
        chk("fl_post.dup", 32'(dup_err), 32'd0);
        chk("fl_post.bd",  32'(batch_done), 32'd0);
        // Slot 1 must still be empty: a fresh write to it is legal.
        step(1'b1, 2'd1, 32'h6000_0001, 1'b0, 1'b0);
        chk("fl_s1.dup", 32'(dup_err), 32'd0);
        st("fl_s1", 1'b0, 2'd0, 3'd1, 16'd16);
        step(1'b1, 2'd0, 32'h6000_0000, 1'b0, 1'b0);
        st("fl_s0", 1'b1, 2'd0, 3'd2, 16'd16);
        chk("fl_s0.instr", ret_instr, 32'h6000_0000);
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 2'd3, 32'h6000_0003, 1'b1, 1'b0);
        st("mid", 1'b0, 2'd2, 3'd1, 16'd18);

        // Async reset mid-batch takes effect without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        st("arst", 1'b0, 2'd0, 3'd0, 16'd0);
        chk("arst.bd",  32'(batch_done), 32'd0);
        chk("arst.dup", 32'(dup_err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'(i), 32'h7000_0000 + 32'(i), 1'b1, 1'b0);
            st("fresh", 1'b1, 2'(i), 3'd1, 16'(i));
            chk("fresh.instr", ret_instr, 32'h7000_0000 + 32'(i));
        end
        step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        st("fresh_end", 1'b0, 2'd0, 3'd0, 16'd4);
        chk("fresh_end.bd", 32'(batch_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
